// File: rtl/uart_pkg.sv
// Shared constants and FSM encodings for the uart_trx 8N1 transceiver.
package uart_pkg;

    localparam int CLK_FREQ_DEF     = 50_000_000;
    localparam int BAUD_DEF         = 115_200;
    localparam int CLKS_PER_BIT_DEF = CLK_FREQ_DEF / BAUD_DEF;
    localparam int HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;
    localparam int DATA_W           = 8;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_DONE  = 3'd4
    } tx_state_t;

    // RX_WAIT is only reachable when the framing-error option is built in
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter 0..CLKS_PER_BIT-1; restart parks it at START_AT, tick on the last count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int START_AT     = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int            CW     = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] RELOAD = CW'(START_AT);

    logic [CW-1:0] r_count;

    // bit-period counter, wraps on tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= RELOAD;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/uart_trx.sv
// Full-duplex 8N1 UART transmitter/receiver.
// Optional stop-bit checking with rx_frame_err output: define UART_FRAMING_ERR_EN.
module uart_trx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = CLK_FREQ_DEF,
    parameter int BAUD         = BAUD_DEF,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              tx_done,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_msg,
    output logic              rx_complete
`ifdef UART_FRAMING_ERR_EN
    ,
    output logic              rx_frame_err
`endif
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    tx_state_t         r_tx_state, w_tx_next;
    logic [DATA_W-1:0] r_tx_shift, w_tx_shift_next;
    logic [2:0]        r_tx_idx;
    logic              r_tx, r_tx_done, w_tx_d, w_tx_done_d;
    logic              w_tx_tick, w_tx_restart;

    rx_state_t         r_rx_state, w_rx_next;
    logic              r_rx_meta, r_rx_sync;
    logic [DATA_W-1:0] r_rx_shift, r_rx_msg;
    logic [2:0]        r_rx_idx;
    logic              r_rx_complete, w_rx_complete_d;
    logic              w_rx_tick, w_rx_restart;
`ifdef UART_FRAMING_ERR_EN
    logic              r_rx_frame_err, w_rx_frame_err_d;
`endif

    assign w_tx_restart = (r_tx_state == TX_IDLE) || (r_tx_state == TX_DONE);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .START_AT(0)) u_tx_timer (
        .i_clk    (clk_50M),
        .i_rst_n  (rst_n),
        .i_restart(w_tx_restart),
        .o_tick   (w_tx_tick)
    );

    // RX timer idles half a bit ahead so its first tick lands on the start-bit midpoint
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .START_AT(CLKS_PER_BIT - HALF_BIT)) u_rx_timer (
        .i_clk    (clk_50M),
        .i_rst_n  (rst_n),
        .i_restart(w_rx_restart),
        .o_tick   (w_rx_tick)
    );

    // TX state and registered line outputs
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx       <= w_tx_d;
            r_tx_done  <= w_tx_done_d;
        end
    end

    // TX next-state
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (tx_en) w_tx_next = TX_START; else w_tx_next = TX_IDLE;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA; else w_tx_next = TX_START;
            TX_DATA:  if (w_tx_tick && (r_tx_idx == 3'd7)) w_tx_next = TX_STOP; else w_tx_next = TX_DATA;
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_DONE; else w_tx_next = TX_STOP;
            TX_DONE:  w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    // TX outputs, derived from the state being entered so the line is registered
    always_comb begin
        w_tx_d      = 1'b1;
        w_tx_done_d = 1'b0;
        case (w_tx_next)
            TX_IDLE:  w_tx_d = 1'b1;
            TX_START: w_tx_d = 1'b0;
            TX_DATA:  w_tx_d = w_tx_shift_next[0];
            TX_STOP:  w_tx_d = 1'b1;
            TX_DONE:  begin w_tx_d = 1'b1; w_tx_done_d = 1'b1; end
            default:  w_tx_d = 1'b1;
        endcase
    end

    // TX shift register next value
    always_comb begin
        w_tx_shift_next = r_tx_shift;
        if ((r_tx_state == TX_IDLE) && tx_en) begin
            w_tx_shift_next = data;
        end else if ((r_tx_state == TX_DATA) && w_tx_tick) begin
            w_tx_shift_next = {1'b0, r_tx_shift[DATA_W-1:1]};
        end else begin
            w_tx_shift_next = r_tx_shift;
        end
    end

    // TX shift register and bit index
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '0;
            r_tx_idx   <= 3'd0;
        end else begin
            r_tx_shift <= w_tx_shift_next;
            if ((r_tx_state == TX_DATA) && w_tx_tick) r_tx_idx <= r_tx_idx + 3'd1;
            else if (r_tx_state == TX_IDLE)           r_tx_idx <= 3'd0;
        end
    end

    assign tx      = r_tx;
    assign tx_done = r_tx_done;

    // rx metastability synchronizer, idles high
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx_restart = (r_rx_state == RX_IDLE) || (r_rx_state == RX_WAIT);

    // RX state and registered outputs
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state     <= RX_IDLE;
            r_rx_complete  <= 1'b0;
            r_rx_msg       <= '0;
`ifdef UART_FRAMING_ERR_EN
            r_rx_frame_err <= 1'b0;
`endif
        end else begin
            r_rx_state     <= w_rx_next;
            r_rx_complete  <= w_rx_complete_d;
            if (w_rx_complete_d) r_rx_msg <= r_rx_shift;
`ifdef UART_FRAMING_ERR_EN
            r_rx_frame_err <= w_rx_frame_err_d;
`endif
        end
    end

    // RX next-state
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START; else w_rx_next = RX_IDLE;
            RX_START: begin
                if (w_rx_tick) begin
                    if (r_rx_sync) w_rx_next = RX_IDLE; else w_rx_next = RX_DATA;
                end else begin
                    w_rx_next = RX_START;
                end
            end
            RX_DATA:  if (w_rx_tick && (r_rx_idx == 3'd7)) w_rx_next = RX_STOP; else w_rx_next = RX_DATA;
`ifdef UART_FRAMING_ERR_EN
            RX_STOP: begin
                if (w_rx_tick) begin
                    if (r_rx_sync) w_rx_next = RX_IDLE; else w_rx_next = RX_WAIT;
                end else begin
                    w_rx_next = RX_STOP;
                end
            end
            RX_WAIT:  if (r_rx_sync) w_rx_next = RX_IDLE; else w_rx_next = RX_WAIT;
`else
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE; else w_rx_next = RX_STOP;
`endif
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // RX output pulses at the stop-bit midpoint
    always_comb begin
`ifdef UART_FRAMING_ERR_EN
        w_rx_complete_d  = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync;
        w_rx_frame_err_d = (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_sync;
`else
        w_rx_complete_d  = (r_rx_state == RX_STOP) && w_rx_tick;
`endif
    end

    // RX shift register (LSB first) and bit index
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift <= '0;
            r_rx_idx   <= 3'd0;
        end else if ((r_rx_state == RX_DATA) && w_rx_tick) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_W-1:1]};
            r_rx_idx   <= r_rx_idx + 3'd1;
        end else if (r_rx_state == RX_IDLE) begin
            r_rx_idx   <= 3'd0;
        end
    end

    assign rx_msg      = r_rx_msg;
    assign rx_complete = r_rx_complete;
`ifdef UART_FRAMING_ERR_EN
    assign rx_frame_err = r_rx_frame_err;
`endif

endmodule

// File: tb/tb_uart_trx.sv
// Scoreboard bench for uart_trx: stimulus pushes expected bytes, monitors decode and compare.
module tb_uart_trx;

    localparam int CPB = 434;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       tx_en;
    logic [7:0] data;
    logic       tx;
    logic       tx_done;
    logic       rx;
    logic [7:0] rx_msg;
    logic       rx_complete;
`ifdef UART_FRAMING_ERR_EN
    logic       rx_frame_err;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int n_tx_done = 0;
    int n_rx_cpl = 0;
    int n_ferr = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] vec[10] = '{8'h00, 8'h80, 8'h01, 8'h55, 8'h2A, 8'h7F, 8'h40, 8'h13, 8'h66, 8'h09};

    always #10 clk_50M = ~clk_50M;

    uart_trx dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .data       (data),
        .tx         (tx),
        .tx_done    (tx_done),
        .rx         (rx),
        .rx_msg     (rx_msg),
        .rx_complete(rx_complete)
`ifdef UART_FRAMING_ERR_EN
        ,
        .rx_frame_err(rx_frame_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // pulse counters and RX scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_50M);
            if (tx_done === 1'b1) n_tx_done++;
`ifdef UART_FRAMING_ERR_EN
            if (rx_frame_err === 1'b1) n_ferr++;
`endif
            if (rx_complete === 1'b1) begin
                n_rx_cpl++;
                if (rx_q.size() == 0) begin
                    check("rx_unexpected", 32'(rx_msg), 32'hFFFF_FFFF);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_data", 32'(rx_msg), 32'(e));
                end
            end
        end
    end

    // TX line monitor: checks every clock of each frame against the expected byte
    initial begin
        logic [7:0] e;
        int bad;
        int idx;
        logic lvl;
        forever begin
            @(negedge clk_50M);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", 32'(tx), 32'd1);
                    repeat (10 * CPB + 1) @(negedge clk_50M);
                end else begin
                    e = tx_q.pop_front();
                    bad = 0;
                    for (int c = 0; c < 10 * CPB; c++) begin
                        idx = c / CPB;
                        if (idx == 0)      lvl = 1'b0;
                        else if (idx == 9) lvl = 1'b1;
                        else               lvl = e[idx-1];
                        if (tx !== lvl || tx_done !== 1'b0) bad++;
                        @(negedge clk_50M);
                    end
                    check("tx_wave_errors", 32'(bad), 32'd0);
                    check("tx_done_at_4340", {30'd0, tx_done, tx}, 32'd3);
                    @(negedge clk_50M);
                    check("tx_done_width", 32'(tx_done), 32'd0);
                end
            end
        end
    end

    task automatic send_tx(input logic [7:0] b);
        int base;
        int waited;
        @(negedge clk_50M);
        base = n_tx_done;
        data = b;
        tx_en = 1'b1;
        tx_q.push_back(b);
        @(negedge clk_50M);
        tx_en = 1'b0;
        data = ~b;
        waited = 0;
        while (n_tx_done == base && waited < 10 * CPB + 50) begin
            @(negedge clk_50M);
            waited++;
        end
        check("tx_done_seen", 32'(n_tx_done - base), 32'd1);
        repeat (2) @(negedge clk_50M);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input logic expect_byte);
        if (expect_byte) rx_q.push_back(b);
        rx = 1'b0;
        repeat (CPB) @(negedge clk_50M);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk_50M);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk_50M);
        if (expect_byte) check("rx_by_stop_end", 32'(rx_q.size()), 32'd0);
        rx = 1'b1;
    endtask

    initial begin
        repeat (150000) @(posedge clk_50M);
        $display("FAIL watchdog: run exceeded 150000 clocks");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        tx_en = 1'b0;
        data  = 8'h00;
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk_50M);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rx_complete", 32'(rx_complete), 32'd0);
        check("rst_rx_msg", 32'(rx_msg), 32'h00);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk_50M);
        check("idle_tx_done_cnt", 32'(n_tx_done), 32'd0);
        check("idle_rx_cpl_cnt", 32'(n_rx_cpl), 32'd0);
        check("idle_tx_line", 32'(tx), 32'd1);

        send_tx(8'hA5);

        base = n_tx_done;
        fork
            send_tx(8'h5A);
            begin
                repeat (2000) @(negedge clk_50M);
                data  = 8'h3C;
                tx_en = 1'b1;
                repeat (3) @(negedge clk_50M);
                tx_en = 1'b0;
            end
        join
        repeat (20) @(negedge clk_50M);
        check("tx_busy_single_done", 32'(n_tx_done - base), 32'd1);
        check("tx_busy_line_idle", 32'(tx), 32'd1);

        drive_rx(8'h7E, 1'b1, 1'b1);
        check("rx_7e_msg", 32'(rx_msg), 32'h7E);

        base = n_rx_cpl;
        rx = 1'b0;
        repeat (100) @(negedge clk_50M);
        rx = 1'b1;
        repeat (400) @(negedge clk_50M);
        check("rx_glitch_no_cpl", 32'(n_rx_cpl - base), 32'd0);
        drive_rx(8'h01, 1'b1, 1'b1);
        check("rx_after_glitch", 32'(rx_msg), 32'h01);

`ifdef UART_FRAMING_ERR_EN
        base = n_ferr;
        drive_rx(8'hC3, 1'b0, 1'b0);
        repeat (50) @(negedge clk_50M);
        check("rx_frame_err_pulse", 32'(n_ferr - base), 32'd1);
        check("rx_frame_msg_kept", 32'(rx_msg), 32'h01);
`endif

        for (int i = 0; i < 10; i++) begin
            fork
                send_tx(vec[i]);
                drive_rx(vec[i], 1'b1, 1'b1);
            join
            repeat (10) @(negedge clk_50M);
            check("loop_rx_msg", 32'(rx_msg), 32'(vec[i]));
        end

        check("tx_q_drained", 32'(tx_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
